// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, condition-code encodings and
// the ALUControl[3] value that marks a logic op.
package alu_pkg;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // ALUControl[3] value selecting a logic op (C and V are not produced).
  localparam logic ALU_LOGIC_SEL = 1'b1;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition-code evaluator against a {V,N,Z,C} flag set.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_ex
);

  logic v, n, z, c;

  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];

  always_comb begin
    // NOTE: default assignment first so every path drives cond_ex and no latch is inferred.
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cond_wb.sv
// Conditional-commit stage after the ALU: flag register, condition check and a
// one-entry valid/ready writeback register. ALU_COND_WB_STICKY_OVF_EN adds a sticky overflow bit.
module alu_cond_wb
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  input  logic         alu_logic,
  input  logic [3:0]   cond,
  input  logic [1:0]   flag_write,
  input  logic         reg_write,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         cond_ex,
  output logic [3:0]   flags_q,
  output logic [N-1:0] wb_result,
  output logic         wb_we,
  output logic         wb_valid,
  input  logic         wb_ready
`ifdef ALU_COND_WB_STICKY_OVF_EN
  ,
  input  logic         clr_sticky,
  output logic         sticky_v
`endif
);

  logic       accept;
  logic       commit;
  logic       cv_write;
  logic [3:0] flags_d;

  cond_check u_cond_check (
    .flags   (flags_q),
    .cond    (cond),
    .cond_ex (cond_ex)
  );

  assign in_ready = ~wb_valid | wb_ready;
  assign accept   = in_valid & in_ready;
  assign commit   = accept & cond_ex;
  // Logic ops never produce C/V, so their C/V write enable is suppressed.
  assign cv_write = flag_write[0] & (alu_logic != ALU_LOGIC_SEL);

  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      if (flag_write[1]) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (cv_write) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // A failed condition still emits a beat (wb_we=0) to keep writeback in order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_result <= '0;
      wb_we     <= 1'b0;
      wb_valid  <= 1'b0;
    end else if (accept) begin
      wb_result <= alu_result;
      wb_we     <= reg_write & cond_ex;
      wb_valid  <= 1'b1;
    end else if (wb_valid && wb_ready) begin
      wb_valid  <= 1'b0;
    end
  end

`ifdef ALU_COND_WB_STICKY_OVF_EN
  logic v_set;

  assign v_set = commit & cv_write & alu_flags[FLAG_V];

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_v <= 1'b0;
    end else if (v_set) begin
      sticky_v <= 1'b1;
    end else if (clr_sticky) begin
      sticky_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cond_wb.sv
// Directed self-checking bench for alu_cond_wb (N=4); sticky-overflow checks
// run when ALU_COND_WB_STICKY_OVF_EN is defined.
module tb_alu_cond_wb;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         alu_logic;
  logic [3:0]   cond;
  logic [1:0]   flag_write;
  logic         reg_write;
  logic         in_valid;
  logic         in_ready;
  logic         cond_ex;
  logic [3:0]   flags_q;
  logic [N-1:0] wb_result;
  logic         wb_we;
  logic         wb_valid;
  logic         wb_ready;
`ifdef ALU_COND_WB_STICKY_OVF_EN
  logic         clr_sticky;
  logic         sticky_v;
`endif

  int checks = 0;
  int errors = 0;

  alu_cond_wb #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .alu_logic  (alu_logic),
    .cond       (cond),
    .flag_write (flag_write),
    .reg_write  (reg_write),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cond_ex    (cond_ex),
    .flags_q    (flags_q),
    .wb_result  (wb_result),
    .wb_we      (wb_we),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready)
`ifdef ALU_COND_WB_STICKY_OVF_EN
    ,
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] res, input logic [3:0] fl, input logic lg,
                        input logic [1:0] fw, input logic [3:0] cc, input logic rw);
    alu_result = res;
    alu_flags  = fl;
    alu_logic  = lg;
    flag_write = fw;
    cond       = cc;
    reg_write  = rw;
    in_valid   = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    alu_result = '0;
    alu_flags  = '0;
    alu_logic  = 1'b0;
    cond       = 4'b1110;
    flag_write = 2'b00;
    reg_write  = 1'b0;
    in_valid   = 1'b0;
    wb_ready   = 1'b1;
`ifdef ALU_COND_WB_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    #12;
    check("reset_flags", 8'(flags_q), 8'h0);
    check("reset_wb_valid", 8'(wb_valid), 8'h0);
    check("reset_wb_we", 8'(wb_we), 8'h0);
    check("reset_in_ready", 8'(in_ready), 8'h1);
    reset_n = 1'b1;
    tick();

    // Overflowing add: 0111+0001 style result 1000 with V=1,N=1
    set_op(4'b1000, 4'b1100, 1'b0, 2'b11, 4'b1110, 1'b1);
    #1 check("add_cond_al", 8'(cond_ex), 8'h1);
    tick();
    in_valid = 1'b0;
    check("add_flags", 8'(flags_q), 8'hC);
    check("add_wb_result", 8'(wb_result), 8'h8);
    check("add_wb_we", 8'(wb_we), 8'h1);
    check("add_wb_valid", 8'(wb_valid), 8'h1);

    // Conditions against flags 1100 (V=1 N=1 Z=0 C=0)
    cond = 4'b0110; #1 check("cond_vs", 8'(cond_ex), 8'h1);
    cond = 4'b1010; #1 check("cond_ge", 8'(cond_ex), 8'h1);
    cond = 4'b1100; #1 check("cond_gt", 8'(cond_ex), 8'h1);
    cond = 4'b1011; #1 check("cond_lt", 8'(cond_ex), 8'h0);
    cond = 4'b1000; #1 check("cond_hi", 8'(cond_ex), 8'h0);
    cond = 4'b1001; #1 check("cond_ls", 8'(cond_ex), 8'h1);
    cond = 4'b1111; #1 check("cond_nv", 8'(cond_ex), 8'h0);
    cond = 4'b0000; #1 check("cond_eq", 8'(cond_ex), 8'h0);

    // Failed EQ op: beat emitted with wb_we=0, flags untouched
    set_op(4'b0101, 4'b0011, 1'b0, 2'b11, 4'b0000, 1'b1);
    tick();
    in_valid = 1'b0;
    check("eqfail_wb_valid", 8'(wb_valid), 8'h1);
    check("eqfail_wb_we", 8'(wb_we), 8'h0);
    check("eqfail_wb_result", 8'(wb_result), 8'h5);
    check("eqfail_flags", 8'(flags_q), 8'hC);

    // Logic op: N,Z load from 1011, V,C hold -> 1010
    set_op(4'b0011, 4'b1011, 1'b1, 2'b11, 4'b1110, 1'b1);
    tick();
    in_valid = 1'b0;
    check("logic_flags", 8'(flags_q), 8'hA);
    check("logic_wb_result", 8'(wb_result), 8'h3);

    // Arith op with flag_write=01: only C,V load from 0101 -> 0011
    set_op(4'b0001, 4'b0101, 1'b0, 2'b01, 4'b1110, 1'b0);
    tick();
    in_valid = 1'b0;
    check("cv_only_flags", 8'(flags_q), 8'h3);
    check("cv_only_wb_we", 8'(wb_we), 8'h0);
    cond = 4'b0000; #1 check("cond_eq_z1", 8'(cond_ex), 8'h1);

    // Drain the output register
    tick();
    check("drain_wb_valid", 8'(wb_valid), 8'h0);
    check("drain_wb_result_hold", 8'(wb_result), 8'h1);

    // Backpressure: op A accepted, op B stalls until wb_ready rises
    wb_ready = 1'b0;
    set_op(4'b1001, 4'b1111, 1'b0, 2'b00, 4'b1110, 1'b1);
    tick();
    check("bp_a_wb_result", 8'(wb_result), 8'h9);
    check("bp_a_flags", 8'(flags_q), 8'h3);
    set_op(4'b0110, 4'b1000, 1'b0, 2'b11, 4'b1110, 1'b1);
    #1 check("bp_in_ready", 8'(in_ready), 8'h0);
    tick();
    check("bp_hold_wb_result", 8'(wb_result), 8'h9);
    check("bp_hold_flags", 8'(flags_q), 8'h3);
    check("bp_hold_wb_valid", 8'(wb_valid), 8'h1);
    wb_ready = 1'b1;
    #1 check("bp_release_in_ready", 8'(in_ready), 8'h1);
    tick();
    check("bp_b_wb_result", 8'(wb_result), 8'h6);
    check("bp_b_wb_valid", 8'(wb_valid), 8'h1);
    check("bp_b_flags", 8'(flags_q), 8'h8);

    // Back-to-back: op1 sets Z, op2 (EQ) sees it the next cycle
    set_op(4'b0000, 4'b0010, 1'b0, 2'b10, 4'b1110, 1'b0);
    tick();
    check("b2b_flags", 8'(flags_q), 8'hA);
    set_op(4'b0111, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b1);
    #1 check("b2b_cond_eq", 8'(cond_ex), 8'h1);
    tick();
    in_valid = 1'b0;
    check("b2b_wb_result", 8'(wb_result), 8'h7);
    check("b2b_wb_we", 8'(wb_we), 8'h1);
    check("b2b_wb_valid", 8'(wb_valid), 8'h1);

    // Reset mid-stream, between clock edges
    #1 reset_n = 1'b0;
    #1;
    check("midrst_wb_valid", 8'(wb_valid), 8'h0);
    check("midrst_wb_we", 8'(wb_we), 8'h0);
    check("midrst_flags", 8'(flags_q), 8'h0);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef ALU_COND_WB_STICKY_OVF_EN
    check("sticky_reset", 8'(sticky_v), 8'h0);
    set_op(4'b0000, 4'b1000, 1'b0, 2'b01, 4'b1110, 1'b0);
    tick();
    set_op(4'b0000, 4'b0000, 1'b0, 2'b01, 4'b1110, 1'b0);
    tick();
    check("sticky_hold", 8'(sticky_v), 8'h1);
    check("sticky_flags_v0", 8'(flags_q), 8'h0);
    set_op(4'b0000, 4'b1000, 1'b0, 2'b01, 4'b1110, 1'b0);
    clr_sticky = 1'b1;
    tick();
    check("sticky_set_wins", 8'(sticky_v), 8'h1);
    in_valid = 1'b0;
    tick();
    clr_sticky = 1'b0;
    check("sticky_clear", 8'(sticky_v), 8'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
